// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point normalisation sequencer.
//   EXP_W / FRAC_W : default exponent and stored-fraction widths
//   EXP_MAX        : all-ones exponent (infinity encoding) for the default width
//   state_e        : sequencer FSM states
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fp_norm_sequencer.sv
// Bit-serial normaliser for an unnormalised mantissa sum.
// It shifts the mantissa register one bit per cycle until the hidden bit is set,
// and adjusts the exponent on each shift. It flags zero, underflow and overflow.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake (in_ready only in IDLE)
//   in_mant           : FRAC_W+2 bits, [FRAC_W+1]=carry, [FRAC_W]=hidden bit
//   in_exp            : biased exponent of in_mant
//   out_valid/out_ready : result handshake (result held in DONE)
//   out_frac, out_exp : normalised fraction (hidden bit removed), exponent
//   out_zero, out_uflow, out_oflow : mutually exclusive result flags
//   busy              : high while in SHIFT
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for an operand, in_ready high
// SHIFT | applying one normalisation rule per cycle
// DONE  | result held on the outputs until out_ready
module fp_norm_sequencer #(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int FRAC_W = fp_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W+1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W-1:0] out_frac,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_uflow,
  output logic              out_oflow,
  output logic              busy
);
  import fp_pkg::*;

  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  state_e              state_q;
  logic [FRAC_W+1:0]   mant_q;
  logic [EXP_W-1:0]    exp_q;
  logic                in_ready_q, busy_q, out_valid_q;
  logic [FRAC_W-1:0]   out_frac_q;
  logic [EXP_W-1:0]    out_exp_q;
  logic                out_zero_q, out_uflow_q, out_oflow_q;

  // Exponent after a carry right shift; only used when exp_q is below all ones.
  logic [EXP_W-1:0]    exp_inc;
  assign exp_inc = exp_q + EXP_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_frac_q  <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
      out_oflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            mant_q      <= in_mant;
            exp_q       <= in_exp;
            out_zero_q  <= 1'b0;
            out_uflow_q <= 1'b0;
            out_oflow_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // Default is to finish this cycle; only the left-shift rule overrides it.
          state_q     <= ST_DONE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          if (exp_q == EXP_ALL1) begin
            // An infinite input stays infinite whatever the mantissa holds.
            out_oflow_q <= 1'b1;
            out_frac_q  <= '0;
            out_exp_q   <= EXP_ALL1;
          end else if (mant_q == '0) begin
            out_zero_q <= 1'b1;
            out_frac_q <= '0;
            out_exp_q  <= '0;
          end else if (mant_q[FRAC_W+1]) begin
            out_exp_q <= exp_inc;
            if (exp_inc == EXP_ALL1) begin
              out_oflow_q <= 1'b1;
              out_frac_q  <= '0;
            end else begin
              out_frac_q <= mant_q[FRAC_W:1];
            end
          end else if (mant_q[FRAC_W]) begin
            out_frac_q <= mant_q[FRAC_W-1:0];
            out_exp_q  <= exp_q;
          end else if (exp_q <= EXP_ONE) begin
            out_uflow_q <= 1'b1;
            out_frac_q  <= '0;
            out_exp_q   <= '0;
          end else begin
            mant_q      <= mant_q << 1;
            exp_q       <= exp_q - EXP_ONE;
            state_q     <= ST_SHIFT;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_frac  = out_frac_q;
  assign out_exp   = out_exp_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;
  assign out_oflow = out_oflow_q;

endmodule

// File: tb/tb_fp_norm_sequencer.sv
module tb_fp_norm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_mant = '0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [22:0] out_frac;
  logic [7:0]  out_exp;
  logic        out_zero, out_uflow, out_oflow, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [30:0] res_q[$];

  fp_norm_sequencer #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_frac(out_frac), .out_exp(out_exp),
    .out_zero(out_zero), .out_uflow(out_uflow), .out_oflow(out_oflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) res_q.push_back({out_exp, out_frac});
  end

  // Offer an operand and return the accept edge index (cyc value after that edge).
  task automatic send(input logic [24:0] m, input logic [7:0] e, output int t);
    bit ok;
    @(negedge clk);
    in_mant = m; in_exp = e; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
      in_valid = 1'b0; t = cyc;
    end else begin
      @(posedge clk); #1;
      t = cyc; in_valid = 1'b0;
    end
  endtask

  // Latency in edges from accept edge to the first edge that samples out_valid high.
  task automatic wait_valid(input int t, output int lat);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = cyc - t + 1; return; end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy: got=%0b%0b exp=00", out_valid, busy); end
    checks++; if (out_frac !== 23'd0 || out_exp !== 8'd0) begin errors++; $display("FAIL reset_data: frac=%h exp=%h exp=0/0", out_frac, out_exp); end
    checks++; if ({out_zero, out_uflow, out_oflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got=%b exp=000", {out_zero, out_uflow, out_oflow}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got=%0b exp=1", in_ready); end
  endtask

  // One operand through the full path with out_ready low until the result shows.
  task automatic run_one(input string nm, input logic [24:0] m, input logic [7:0] e,
                         input int x_lat, input logic [22:0] x_frac, input logic [7:0] x_exp,
                         input logic [2:0] x_flags);
    int t, lat;
    send(m, e, t);
    wait_valid(t, lat);
    checks++; if (lat !== x_lat) begin errors++; $display("FAIL %s_latency: got=%0d exp=%0d", nm, lat, x_lat); end
    checks++; if (out_frac !== x_frac || out_exp !== x_exp) begin errors++; $display("FAIL %s_data: frac=%h exp=%h required frac=%h exp=%h", nm, out_frac, out_exp, x_frac, x_exp); end
    checks++; if ({out_zero, out_uflow, out_oflow} !== x_flags) begin errors++; $display("FAIL %s_flags: got=%b exp=%b", nm, {out_zero, out_uflow, out_oflow}, x_flags); end
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL %s_release: valid=%0b ready=%0b exp 0/1", nm, out_valid, in_ready); end
  endtask

  task automatic test_normalised();
    run_one("norm_unit", 25'h0800000, 8'h80, 2, 23'h000000, 8'h80, 3'b000);
    run_one("norm_mix",  25'h0ABCDEF, 8'h40, 2, 23'h2BCDEF, 8'h40, 3'b000);
  endtask

  task automatic test_carry();
    run_one("carry_unit", 25'h1000000, 8'h80, 2, 23'h000000, 8'h81, 3'b000);
    run_one("carry_ones", 25'h1FFFFFF, 8'h10, 2, 23'h7FFFFF, 8'h11, 3'b000);
    run_one("carry_oflow", 25'h1000000, 8'hFE, 2, 23'h000000, 8'hFF, 3'b001);
  endtask

  task automatic test_inf_input();
    run_one("inf_mant", 25'h0400000, 8'hFF, 2, 23'h000000, 8'hFF, 3'b001);
    run_one("inf_zero", 25'h0000000, 8'hFF, 2, 23'h000000, 8'hFF, 3'b001);
  endtask

  task automatic test_shift();
    run_one("shift_one",  25'h0400000, 8'h80, 3,  23'h000000, 8'h7F, 3'b000);
    run_one("shift_22",   25'h0000003, 8'h80, 24, 23'h400000, 8'h6A, 3'b000);
    run_one("shift_max",  25'h0000001, 8'h80, 25, 23'h000000, 8'h69, 3'b000);
    run_one("shift_uflow", 25'h0000001, 8'h05, 6, 23'h000000, 8'h00, 3'b010);
  endtask

  task automatic test_zero_hold();
    int t, lat;
    send(25'h0000000, 8'h33, t);
    wait_valid(t, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency: got=%0d exp=2", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_mant = 25'h0800000 + 25'(i); in_exp = 8'h20;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
          out_zero !== 1'b1 || out_uflow !== 1'b0 || out_oflow !== 1'b0 ||
          out_frac !== 23'd0 || out_exp !== 8'd0) begin
        errors++;
        $display("FAIL zero_hold_%0d: v=%0b r=%0b b=%0b z=%0b u=%0b o=%0b frac=%h exp=%h required 1 0 0 1 0 0 0 0",
                 i, out_valid, in_ready, busy, out_zero, out_uflow, out_oflow, out_frac, out_exp);
      end
    end
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL zero_release: valid=%0b ready=%0b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_rst_mid_shift();
    int t, lat, n0;
    out_ready = 1'b1;
    n0 = res_q.size();
    send(25'h0000100, 8'h80, t);
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: busy=%0b valid=%0b exp 1/0", busy, out_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_state: ready=%0b valid=%0b busy=%0b exp 1/0/0", in_ready, out_valid, busy); end
    repeat (30) @(negedge clk);
    checks++; if (res_q.size() !== n0) begin errors++; $display("FAIL rst_mid_no_result: transfers=%0d exp=%0d", res_q.size(), n0); end
    send(25'h0800000, 8'h22, t);
    wait_valid(t, lat);
    checks++; if (lat !== 2 || out_exp !== 8'h22 || out_frac !== 23'd0) begin errors++; $display("FAIL rst_mid_next: lat=%0d exp=%h frac=%h required 2/22/0", lat, out_exp, out_frac); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (res_q.size() !== n0 + 1) begin errors++; $display("FAIL rst_mid_next_count: transfers=%0d exp=%0d", res_q.size(), n0 + 1); end
  endtask

  task automatic test_back_to_back();
    logic [24:0] m_tab [4];
    logic [7:0]  e_tab [4];
    logic [30:0] x_tab [4];
    int t_prev, t;
    bit ok;
    m_tab[0] = 25'h0800001; e_tab[0] = 8'h10; x_tab[0] = {8'h10, 23'h000001};
    m_tab[1] = 25'h0FFFFFF; e_tab[1] = 8'h20; x_tab[1] = {8'h20, 23'h7FFFFF};
    m_tab[2] = 25'h0C00000; e_tab[2] = 8'h30; x_tab[2] = {8'h30, 23'h400000};
    m_tab[3] = 25'h0812345; e_tab[3] = 8'h40; x_tab[3] = {8'h40, 23'h012345};
    res_q.delete();
    out_ready = 1'b1;
    t_prev = 0;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_mant = m_tab[i]; in_exp = e_tab[i]; ok = 1'b0;
      for (int w = 0; w < 20; w++) begin
        if (in_ready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL b2b_accept_%0d: in_ready=%0b required=1", i, in_ready);
      end else begin
        @(posedge clk); #1;
        t = cyc;
        if (i > 0) begin
          checks++; if (t - t_prev !== 3) begin errors++; $display("FAIL b2b_interval_%0d: got=%0d exp=3", i, t - t_prev); end
        end
        t_prev = t;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    out_ready = 1'b0;
    checks++; if (res_q.size() !== 4) begin errors++; $display("FAIL b2b_count: got=%0d exp=4", res_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < res_q.size()) begin
        checks++; if (res_q[i] !== x_tab[i]) begin errors++; $display("FAIL b2b_result_%0d: got=%h exp=%h", i, res_q[i], x_tab[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_normalised();
    test_carry();
    test_inf_input();
    test_shift();
    test_zero_hold();
    test_rst_mid_shift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
